// File: rtl/dsi_pkg.sv
// Shared definitions for the DSI packet builder slice.
// Holds data-type constants, the builder FSM state type, the CRC polynomial
// and the header ECC / CRC byte-update helper functions.
package dsi_pkg;

  // DSI data types used by the upstream packet assembler
  localparam logic [5:0] DT_VSS      = 6'h01;
  localparam logic [5:0] DT_VSE      = 6'h11;
  localparam logic [5:0] DT_HSS      = 6'h21;
  localparam logic [5:0] DT_HSE      = 6'h31;
  localparam logic [5:0] DT_BLANKING = 6'h19;
  localparam logic [5:0] DT_RGB888   = 6'h3E;
  localparam logic [5:0] DT_EOTP     = 6'h08;

  // x^16+x^12+x^5+1, bit-reversed for LSB-first shifting
  localparam logic [15:0] CRC_POLY = 16'h8408;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CRC_LO  = 3'd3,
    ST_CRC_HI  = 3'd4
  } state_t;

  // 6-bit Hamming ECC over the 24 header bits, d[0] = DI bit 0
  function automatic logic [7:0] dsi_ecc(input logic [23:0] d);
    logic [7:0] e;
    e    = 8'h00;
    e[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    e[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    e[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    e[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    e[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    e[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return e;
  endfunction

  // Reflected CRC-16 update for one byte, LSB first, no final XOR
  function automatic logic [15:0] crc16_byte_update(input logic [15:0] crc,
                                                    input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = {1'b0, c[15:1]} ^ CRC_POLY;
      end else begin
        c = {1'b0, c[15:1]};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/dsi_packet_builder_if.sv
// Handshake bundle of the DSI packet builder.
// Command channel (cmd_*), payload byte channel (pld_*), output byte
// channel (out_*) and the busy status. The builder uses the slave modport,
// the upstream/downstream side uses master.
interface dsi_packet_builder_if;
  import dsi_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_dt;
  logic [1:0]  cmd_vc;
  logic [15:0] cmd_wc;
  logic        cmd_long;
  logic        pld_valid;
  logic        pld_ready;
  logic [7:0]  pld_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic        busy;

  modport slave (
    input  cmd_valid, cmd_dt, cmd_vc, cmd_wc, cmd_long,
    input  pld_valid, pld_data, out_ready,
    output cmd_ready, pld_ready, out_valid, out_data, out_sop, out_eop, busy
  );

  modport master (
    output cmd_valid, cmd_dt, cmd_vc, cmd_wc, cmd_long,
    output pld_valid, pld_data, out_ready,
    input  cmd_ready, pld_ready, out_valid, out_data, out_sop, out_eop, busy
  );

endinterface

// File: rtl/dsi_crc16_byte.sv
// Byte-wide CRC-16 accumulator for the long-packet footer.
// Ports: clk, rst_n (async active-low), init (reload seed), en (fold data
// into the CRC), data (byte), crc (current accumulated value).
module dsi_crc16_byte
  import dsi_pkg::*;
#(
  parameter logic [15:0] CRC_SEED = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_r;

  // CRC register: seed on reset/init, fold one byte per enabled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_r <= CRC_SEED;
    end else if (init) begin
      crc_r <= CRC_SEED;
    end else if (en) begin
      crc_r <= crc16_byte_update(crc_r, data);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/dsi_packet_builder.sv
// DSI packet builder: turns one packet command plus a payload byte stream
// into a byte stream of header (DI, WC lo, WC hi, ECC), payload and, for
// long packets, a 2-byte CRC footer.
// Ports: clk, rst_n (async active-low), bus (slave side of
// dsi_packet_builder_if: cmd_*, pld_*, out_*, busy).
module dsi_packet_builder
  import dsi_pkg::*;
#(
  parameter logic [15:0] CRC_SEED = 16'hFFFF,
  parameter bit          ECC_EN   = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  dsi_packet_builder_if.slave bus
);

  state_t      state_r, state_s;
  logic [1:0]  hdr_idx_r;
  logic [5:0]  dt_r;
  logic [1:0]  vc_r;
  logic [15:0] wc_r;
  logic        long_r;
  logic [15:0] cnt_r;
  logic [15:0] crc_s;
  logic [7:0]  ecc_s;

  logic        cmd_ready_s, pld_ready_s, out_valid_s, sop_s, eop_s;
  logic [7:0]  out_data_s;
  logic        cmd_xfer_s, hdr_xfer_s, pld_xfer_s;

  assign cmd_xfer_s = bus.cmd_valid && cmd_ready_s;
  assign hdr_xfer_s = (state_r == ST_HDR) && bus.out_ready;
  assign pld_xfer_s = (state_r == ST_PAYLOAD) && bus.pld_valid && bus.out_ready;
  assign ecc_s      = ECC_EN ? dsi_ecc({wc_r, vc_r, dt_r}) : 8'h00;

  dsi_crc16_byte #(.CRC_SEED(CRC_SEED)) u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (cmd_xfer_s),
    .en    (pld_xfer_s),
    .data  (bus.pld_data),
    .crc   (crc_s)
  );

  // State, latched command, header index and payload counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      hdr_idx_r <= 2'd0;
      dt_r      <= 6'd0;
      vc_r      <= 2'd0;
      wc_r      <= 16'd0;
      long_r    <= 1'b0;
      cnt_r     <= 16'd0;
    end else begin
      state_r <= state_s;
      if (cmd_xfer_s) begin
        dt_r      <= bus.cmd_dt;
        vc_r      <= bus.cmd_vc;
        wc_r      <= bus.cmd_wc;
        long_r    <= bus.cmd_long;
        hdr_idx_r <= 2'd0;
        cnt_r     <= bus.cmd_wc;
      end else begin
        if (hdr_xfer_s) begin
          hdr_idx_r <= hdr_idx_r + 2'd1;
        end
        // Only decremented in PAYLOAD, which is left when cnt_r hits 1
        if (pld_xfer_s) begin
          cnt_r <= cnt_r - 16'd1;
        end
      end
    end
  end

  // Next state and per-state output byte/handshake selection
  always_comb begin
    state_s     = state_r;
    cmd_ready_s = 1'b0;
    pld_ready_s = 1'b0;
    out_valid_s = 1'b0;
    out_data_s  = 8'h00;
    sop_s       = 1'b0;
    eop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready_s = 1'b1;
        if (bus.cmd_valid) begin
          state_s = ST_HDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        out_valid_s = 1'b1;
        case (hdr_idx_r)
          2'd0: begin
            out_data_s = {vc_r, dt_r};
            sop_s      = 1'b1;
          end
          2'd1: out_data_s = wc_r[7:0];
          2'd2: out_data_s = wc_r[15:8];
          2'd3: begin
            out_data_s = ecc_s;
            eop_s      = !long_r;
          end
          default: out_data_s = 8'h00;
        endcase
        if (bus.out_ready && (hdr_idx_r == 2'd3)) begin
          if (!long_r) begin
            state_s = ST_IDLE;
          end else if (wc_r != 16'd0) begin
            state_s = ST_PAYLOAD;
          end else begin
            state_s = ST_CRC_LO;
          end
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_PAYLOAD: begin
        // Pass-through: upstream byte goes straight to the output
        out_valid_s = bus.pld_valid;
        out_data_s  = bus.pld_data;
        pld_ready_s = bus.out_ready;
        if (pld_xfer_s && (cnt_r == 16'd1)) begin
          state_s = ST_CRC_LO;
        end else begin
          state_s = ST_PAYLOAD;
        end
      end
      ST_CRC_LO: begin
        out_valid_s = 1'b1;
        out_data_s  = crc_s[7:0];
        if (bus.out_ready) begin
          state_s = ST_CRC_HI;
        end else begin
          state_s = ST_CRC_LO;
        end
      end
      ST_CRC_HI: begin
        out_valid_s = 1'b1;
        out_data_s  = crc_s[15:8];
        eop_s       = 1'b1;
        if (bus.out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_CRC_HI;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = cmd_ready_s;
  assign bus.pld_ready = pld_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_data_s;
  assign bus.out_sop   = sop_s;
  assign bus.out_eop   = eop_s;
  assign bus.busy      = (state_r != ST_IDLE);

endmodule

// File: doc/dsi_packet_builder.md
Name: dsi_packet_builder

Overview:
- Downstream of the DSI packet assembler FSM (VSS/HSS/HBP/RGB/HFP/LPM sequencing).
- Accepts one packet command at a time (data type, virtual channel, word count, short/long flag) plus a byte-wide payload stream.
- Emits the packet as a byte stream: 4-byte header with ECC, payload bytes, then 2-byte CRC footer (long packets only).
- Output feeds the lane distributor / HS serializer.

Parameters:
- CRC_SEED, 16'hFFFF, initial CRC-16 register value per long packet.
- ECC_EN, 1, 1 = compute ECC byte; 0 = send 8'h00 in the ECC position (debug only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  packet command valid
- cmd_ready  out  1  builder idle, command accepted on valid&&ready
- cmd_dt  in  6  DSI data type
- cmd_vc  in  2  virtual channel
- cmd_wc  in  16  long: payload byte count; short: {data1,data0}
- cmd_long  in  1  1 = long packet
- pld_valid  in  1  payload byte valid
- pld_ready  out  1  payload byte accepted on valid&&ready
- pld_data  in  8  payload byte
- out_valid  out  1  output byte valid
- out_ready  in  1  downstream accepts byte
- out_data  out  8  packet byte
- out_sop  out  1  first byte (DI) of packet
- out_eop  out  1  last byte of packet
- busy  out  1  packet in progress

Behaviour:
- Reset (async, while rst_n low):
  - state=IDLE; cmd_ready=1; out_valid=0; pld_ready=0; out_data=0; out_sop=0; out_eop=0; busy=0.
  - Byte counter=0; CRC register=CRC_SEED.
  - Reset mid-packet abandons the packet; no partial bytes after reset.
- FSM states: IDLE, HDR, PAYLOAD, CRC_LO, CRC_HI.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch dt/vc/wc/long, compute ECC combinationally from the latched header, go to HDR with hdr_idx=0.
- HDR:
  - Byte order: DI={vc,dt}, wc[7:0], wc[15:8], ECC.
  - Index advances only on out_valid&&out_ready.
  - After the ECC byte: short -> IDLE; long with wc!=0 -> PAYLOAD; long with wc==0 -> CRC_LO.
- PAYLOAD:
  - out_valid=pld_valid, out_data=pld_data, pld_ready=out_ready (pass-through, zero added latency).
  - Byte counter loads wc and decrements per transfer; CRC updated per transferred byte.
  - Counter reaching 0 -> CRC_LO.
- CRC_LO / CRC_HI: send crc[7:0], then crc[15:8]; CRC_HI transfer -> IDLE.
- Handshake rules:
  - Output byte and flags are held stable while out_valid&&!out_ready.
  - cmd_ready=0 outside IDLE.
  - pld_ready=0 outside PAYLOAD.
- Output flags:
  - out_sop=1 on the DI byte only.
  - out_eop=1 on the ECC byte (short packets) or CRC_HI (long packets).
- Back-to-back packets:
  - A new command may be accepted in IDLE the cycle after the eop transfer.
  - One idle cycle between packets is permitted.
- ECC: DSI 6-bit Hamming over the 24 header bits (DI bit0 = bit 0). ecc[7:6]=0.
- CRC: CRC-16 polynomial x^16+x^12+x^5+1, reflected (0x8408), LSB-first, seed CRC_SEED, no final XOR.
- Widths:
  - Word count is unsigned 16-bit; max payload 65535 bytes.
  - Counter is 16-bit and never wraps, because zero is checked before the decrement.
- Upstream stall in PAYLOAD (pld_valid=0): out_valid=0 and the counter holds. No timeout.
- busy=1 from command acceptance through the eop transfer.

Decomposition:
- Shared package dsi_pkg:
  - DSI data-type constants: VSS=6'h01, VSE=6'h11, HSS=6'h21, HSE=6'h31, BLANKING=6'h19, RGB888=6'h3E, EOTP=6'h08.
  - FSM state enum.
  - CRC polynomial constant.
- ECC and CRC byte-update as package functions.
- Sub-module dsi_crc16_byte: combinational-plus-register CRC accumulator with init and enable.

Test Plan:
- Short VSS: dt=01, vc=0, wc=0000, long=0, out_ready=1 -> bytes 01 00 00 07; sop on byte0, eop on byte3; cmd_ready back to 1 next cycle.
- Short HSS: dt=21, wc=0000 -> 21 00 00 12. vc=2, dt=01 -> DI=81, ECC matches reference model.
- Long, empty payload: dt=19, wc=0000, long=1 -> 19 00 00 ECC, then FF FF with eop on the last byte; pld_ready never asserted.
- Long, ASCII "123456789": wc=0009 -> header, 9 payload bytes, CRC bytes 91 6F; counter reaches 0 exactly at byte 9.
- Backpressure and stalls during a long packet: random out_ready and random pld_valid gaps -> stream identical to the no-stall run; out_data stable while stalled; no payload byte lost or duplicated.
- Reset mid-PAYLOAD: after 3 of 10 bytes, pulse rst_n low -> all outputs at reset values immediately; the next command produces a correct full packet starting with sop.
